write_address_counter: RTL and testbench

Write-side companion to the register-file read path. Accepts result words from the compute stage with a valid/ready handshake. Steps a one-hot ring pointer across DATANUM entries, encodes it to a binary write address, and issues registered write strobes to the register file. Flags full/done so the read side can start draining.

---
 rtl/write_address_counter_pkg.sv | 30 +++
 rtl/write_address_counter_ring.sv | 24 ++
 rtl/write_address_counter.sv | 94 +++++++++
 tb/tb_write_address_counter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/write_address_counter_pkg.sv
// Shared types, default sizes and the one-hot encoder used by both the write-side
// and the read-side register-file counters.
package write_address_counter_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wac_state_t;

  localparam int WAC_ADDRESS   = 4;
  localparam int WAC_DATAWIDTH = 8;
  localparam int WAC_DATANUM   = 15;

  // Index of the single set bit; returns 0 for an all-zero or multi-hot input.
  // Supports pointers up to 32 entries wide.
  function automatic logic [31:0] onehot_encode(input logic [31:0] onehot);
    logic [31:0] idx;
    int          hits;
    idx  = '0;
    hits = 0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) begin
        idx  = 32'(i);
        hits = hits + 1;
      end
    end
    return (hits == 1) ? idx : '0;
  endfunction

endpackage

// File: rtl/write_address_counter_ring.sv
// ring_pointer_x1: enabled one-hot rotator with a synchronous load to entry INIT.
module ring_pointer_x1 #(
  parameter int N    = 15,
  parameter int INIT = 0
) (
  input  logic         clk,
  input  logic         load,
  input  logic         en,
  output logic [N-1:0] ptr
);

  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] INIT_PTR = ONE << INIT;

  // Load wins over rotate so a restart never lands one entry late.
  always_ff @(posedge clk) begin
    if (load) begin
      ptr <= INIT_PTR;
    end else if (en) begin
      ptr <= {ptr[N-2:0], ptr[N-1]};
    end
  end

endmodule

// File: rtl/write_address_counter.sv
// Write-side register-file address counter: accepts words, strobes them out with an
// encoded ring-pointer address one cycle later. WAC_WRAP_EN selects overwrite-on-wrap.
module write_address_counter
  import write_address_counter_pkg::*;
#(
  parameter int ADDRESS        = WAC_ADDRESS,
  parameter int DATAWIDTH      = WAC_DATAWIDTH,
  parameter int DATANUM        = WAC_DATANUM,
  parameter int INIT_WRITE_REG = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 WriteEn,
  output logic [ADDRESS-1:0]   WriteReg,
  output logic [DATAWIDTH-1:0] WriteData,
  output logic                 full,
  output logic                 done,
  output wac_state_t           state_dbg
);

  localparam int CNT_W = $clog2(DATANUM + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATANUM - 1);

  // Handshake: a word transfers on a clk edge where in_valid and in_ready are both
  // high and clear is low; in_valid may rise at any time, in_ready depends only on state.
  wac_state_t           state;
  logic [CNT_W-1:0]     count;
  logic [DATANUM-1:0]   ptr;
  logic [ADDRESS-1:0]   enc;
  logic                 accept;
  logic                 load;

  assign in_ready  = ~rst_n & (state == FILL);
  assign accept    = in_valid & in_ready & ~clear;
  assign load      = rst_n | clear;
  assign enc       = ADDRESS'(onehot_encode(32'(ptr)));
  assign state_dbg = state;

  ring_pointer_x1 #(
    .N    (DATANUM),
    .INIT (INIT_WRITE_REG)
  ) u_ring (
    .clk  (clk),
    .load (load),
    .en   (accept),
    .ptr  (ptr)
  );

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= FILL;
      count     <= '0;
      WriteEn   <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      full      <= 1'b0;
      done      <= 1'b0;
    end else if (clear) begin
      // WriteReg/WriteData keep their last values across a frame restart.
      state   <= FILL;
      count   <= '0;
      WriteEn <= 1'b0;
      full    <= 1'b0;
      done    <= 1'b0;
    end else begin
      WriteEn <= accept;
      done    <= 1'b0;
      if (accept) begin
        WriteReg  <= enc;
        WriteData <= in_data;
        if (count == LAST_CNT) begin
          done <= 1'b1;
          full <= 1'b1;
`ifdef WAC_WRAP_EN
          count <= '0;
`else
          count <= count + 1'b1;
          state <= FULL;
`endif
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

  a_ptr_onehot: assert property (@(posedge clk) disable iff (rst_n) $onehot(ptr))
    else $error("write pointer is not one-hot: %b", ptr);

endmodule

// File: tb/tb_write_address_counter.sv
// Bench for write_address_counter: two instances (INIT_WRITE_REG 0 and 13) share
// stimulus; a behavioural model feeds per-instance expected-write queues.
module tb_write_address_counter;
  import write_address_counter_pkg::*;

  localparam int ADDRESS   = 4;
  localparam int DATAWIDTH = 8;
  localparam int DATANUM   = 15;
  localparam int INITS [2] = '{0, 13};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n    = 1'b1;
  logic                 clear    = 1'b0;
  logic                 in_valid = 1'b0;
  logic [DATAWIDTH-1:0] in_data  = '0;

  logic [1:0]           rdy, wen, fl, dn;
  logic [ADDRESS-1:0]   wreg  [2];
  logic [DATAWIDTH-1:0] wdata [2];
  wac_state_t           st    [2];

  write_address_counter #(.ADDRESS(ADDRESS), .DATAWIDTH(DATAWIDTH), .DATANUM(DATANUM),
                          .INIT_WRITE_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[0]), .WriteEn(wen[0]), .WriteReg(wreg[0]), .WriteData(wdata[0]),
    .full(fl[0]), .done(dn[0]), .state_dbg(st[0])
  );

  write_address_counter #(.ADDRESS(ADDRESS), .DATAWIDTH(DATAWIDTH), .DATANUM(DATANUM),
                          .INIT_WRITE_REG(13)) u_dut13 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy[1]), .WriteEn(wen[1]), .WriteReg(wreg[1]), .WriteData(wdata[1]),
    .full(fl[1]), .done(dn[1]), .state_dbg(st[1])
  );

  // scoreboard
  logic [ADDRESS+DATAWIDTH-1:0] exp_q0[$];
  logic [ADDRESS+DATAWIDTH-1:0] exp_q1[$];
  int checks = 0;
  int errors = 0;

  int                   m_idx  [2];
  int                   m_cnt  [2];
  bit                   m_stop [2];
  bit                   m_full [2];
  bit                   m_done [2];
  bit                   m_en   [2];
  logic [ADDRESS-1:0]   m_addr [2];
  logic [DATAWIDTH-1:0] m_data [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: one clock of stimulus, model update, then output comparison
  task automatic step(input logic v, input logic [DATAWIDTH-1:0] d,
                      input logic clr, input logic rst);
    logic                         acc;
    logic [ADDRESS+DATAWIDTH-1:0] e;
    bit                           empty;
    rst_n = rst; clear = clr; in_valid = v; in_data = d;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("in_ready%0d", i), 32'(rdy[i]), 32'(!rst && !m_stop[i]));
      acc = v && !rst && !clr && !m_stop[i];
      if (rst) begin
        m_idx[i] = INITS[i]; m_cnt[i] = 0; m_stop[i] = 0; m_full[i] = 0;
        m_done[i] = 0; m_en[i] = 0; m_addr[i] = '0; m_data[i] = '0;
        if (i == 0) exp_q0.delete(); else exp_q1.delete();
      end else if (clr) begin
        m_idx[i] = INITS[i]; m_cnt[i] = 0; m_stop[i] = 0; m_full[i] = 0;
        m_done[i] = 0; m_en[i] = 0;
      end else begin
        m_en[i]   = acc;
        m_done[i] = 0;
        if (acc) begin
          m_addr[i] = ADDRESS'(m_idx[i]);
          m_data[i] = d;
          if (i == 0) exp_q0.push_back({m_addr[i], d});
          else        exp_q1.push_back({m_addr[i], d});
          m_idx[i] = (m_idx[i] + 1) % DATANUM;
          m_cnt[i]++;
          if (m_cnt[i] == DATANUM) begin
            m_done[i] = 1;
            m_full[i] = 1;
`ifdef WAC_WRAP_EN
            m_cnt[i] = 0;
`else
            m_stop[i] = 1;
`endif
          end
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("wen%0d", i),   32'(wen[i]), 32'(m_en[i]));
      check($sformatf("done%0d", i),  32'(dn[i]),  32'(m_done[i]));
      check($sformatf("full%0d", i),  32'(fl[i]),  32'(m_full[i]));
      check($sformatf("state%0d", i), 32'(st[i]),  32'(m_stop[i] ? FULL : FILL));
      if (wen[i]) begin
        empty = (i == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        if (empty) begin
          check($sformatf("q_underflow%0d", i), 32'd1, 32'd0);
        end else begin
          e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check($sformatf("wreg%0d", i),  32'(wreg[i]),  32'(e[ADDRESS+DATAWIDTH-1:DATAWIDTH]));
          check($sformatf("wdata%0d", i), 32'(wdata[i]), 32'(e[DATAWIDTH-1:0]));
        end
      end else begin
        check($sformatf("wreg_hold%0d", i),  32'(wreg[i]),  32'(m_addr[i]));
        check($sformatf("wdata_hold%0d", i), 32'(wdata[i]), 32'(m_data[i]));
      end
    end
  endtask

  initial begin
    // reset
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 1'b0, 1'b1);

    // back-to-back fill with 0x10..0x1E
    for (int k = 0; k < 15; k++) step(1'b1, DATAWIDTH'(8'h10 + k), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // valid held while full
    for (int k = 0; k < 5; k++) step(1'b1, DATAWIDTH'(8'hA0 + k), 1'b0, 1'b0);

    // clear wins over a simultaneous word, then a fresh frame starts at INIT
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // gapped valid, every third cycle
    step(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 24; k++)
      step((k % 3) == 0, DATAWIDTH'($urandom_range(0, 255)), 1'b0, 1'b0);

    // reset mid-frame after 7 accepts, with a word offered on the reset edge
    step(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) step(1'b1, DATAWIDTH'($urandom_range(0, 255)), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) step(1'b1, DATAWIDTH'($urandom_range(0, 255)), 1'b0, 1'b0);

    // long run: wraps twice when overwrite is enabled, stops at full otherwise
    step(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 32; k++) step(1'b1, DATAWIDTH'($urandom_range(0, 255)), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    check("queue_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
